// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
// Bubble encoding, default reset PC, fetch FSM states and the IF/ID bundle.
package if_fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pcplus4;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, talks req/ready + rvalid to imem,
// parks a word while stalled and squashes in-flight fetches on redirect.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = if_fetch_stage_pkg::DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] PCplusfour,
   output logic [31:0] Instr,
   output logic        instr_valid
);

   import if_fetch_stage_pkg::*;

   fetch_state_e state_q, state_d;
   logic         kill_q, kill_d;
   logic [31:0]  pc_q;
   logic [31:0]  hold_q;
   logic [31:0]  word;
   logic         deliver;
   logic         capture;
   if_id_t       out_q;

   assign imem_req    = (state_q == REQ) & ~rst;
   assign imem_addr   = pc_q;
   assign PC          = out_q.pc;
   assign PCplusfour  = out_q.pcplus4;
   assign Instr       = out_q.instr;
   assign instr_valid = out_q.valid;

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      deliver = 1'b0;
      capture = 1'b0;
      word    = hold_q;
      unique case (state_q)
         REQ: begin
            if (imem_ready) state_d = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = REQ;
               end else if (!stall) begin
                  deliver = 1'b1;
                  word    = imem_rdata;
                  state_d = REQ;
               end else begin
                  capture = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (!stall) begin
               deliver = 1'b1;
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase
      // Redirect wins over stall and deliver; an accepted old request
      // still owes us a response, which must be swallowed.
      if (redirect_valid) begin
         deliver = 1'b0;
         capture = 1'b0;
         unique case (state_q)
            REQ:  kill_d = imem_ready;
            WAIT: begin
               kill_d  = ~imem_rvalid;
               state_d = imem_rvalid ? REQ : WAIT;
            end
            HOLD: state_d = REQ;
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= REQ;
         kill_q        <= 1'b0;
         pc_q          <= RESET_PC;
         hold_q        <= NOP_INSTR;
         out_q.pc      <= RESET_PC;
         out_q.pcplus4 <= RESET_PC + 32'd4;
         out_q.instr   <= NOP_INSTR;
         out_q.valid   <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
         if (capture) hold_q <= imem_rdata;
         if (redirect_valid) begin
            pc_q        <= {redirect_pc[31:2], 2'b00};
            hold_q      <= NOP_INSTR;
            out_q.instr <= NOP_INSTR;
            out_q.valid <= 1'b0;
         end else if (deliver) begin
            pc_q          <= pc_q + 32'd4;
            out_q.pc      <= pc_q;
            out_q.pcplus4 <= pc_q + 32'd4;
            out_q.instr   <= word;
            out_q.valid   <= 1'b1;
         end else if (!stall) begin
            out_q.instr <= NOP_INSTR;
            out_q.valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed cycle-by-cycle vectors for the fetch stage: handshake,
// stall hold, redirect squash, mid-flight reset and PC wraparound.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] PC;
   logic [31:0] PCplusfour;
   logic [31:0] Instr;
   logic        instr_valid;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .PC             (PC),
      .PCplusfour     (PCplusfour),
      .Instr          (Instr),
      .instr_valid    (instr_valid)
   );

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        rvalid;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic [31:0] e_pc4;
   } vec_t;

   int total  = 0;
   int passed = 0;
   int row    = 0;

   function automatic vec_t v(
      input logic r, input logic s, input logic rd, input logic [31:0] rp,
      input logic rdy, input logic rv, input logic [31:0] dat,
      input logic eq, input logic [31:0] ea, input logic ev,
      input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ep4);
      vec_t t;
      t.rst = r; t.stall = s; t.redir = rd; t.rpc = rp;
      t.ready = rdy; t.rvalid = rv; t.rdata = dat;
      t.e_req = eq; t.e_addr = ea; t.e_valid = ev;
      t.e_instr = ei; t.e_pc = ep; t.e_pc4 = ep4;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
   endtask

   // Called just after a negedge: drive, check comb outputs, clock, check regs.
   task automatic run(input vec_t t);
      rst            = t.rst;
      stall          = t.stall;
      redirect_valid = t.redir;
      redirect_pc    = t.rpc;
      imem_ready     = t.ready;
      imem_rvalid    = t.rvalid;
      imem_rdata     = t.rdata;
      #1;
      chk("imem_req", {31'd0, imem_req}, {31'd0, t.e_req});
      chk("imem_addr", imem_addr, t.e_addr);
      @(posedge clk);
      #1;
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, t.e_valid});
      chk("Instr", Instr, t.e_instr);
      chk("PC", PC, t.e_pc);
      chk("PCplusfour", PCplusfour, t.e_pc4);
      @(negedge clk);
      row++;
   endtask

   vec_t tbl[12];

   initial begin
      // rst st rd rpc  rdy rv rdata  | req addr val instr pc pc4
      tbl[0]  = v(1,0,0,0, 0,0,0,             0,32'h0,0,NOP,32'h0,32'h4);
      tbl[1]  = v(0,0,0,0, 1,0,0,             1,32'h0,0,NOP,32'h0,32'h4);
      tbl[2]  = v(0,0,0,0, 0,1,32'hA000_0000, 0,32'h0,1,32'hA000_0000,32'h0,32'h4);
      tbl[3]  = v(0,0,0,0, 1,0,0,             1,32'h4,0,NOP,32'h0,32'h4);
      tbl[4]  = v(0,0,0,0, 0,1,32'hA000_0004, 0,32'h4,1,32'hA000_0004,32'h4,32'h8);
      tbl[5]  = v(0,0,0,0, 1,0,0,             1,32'h8,0,NOP,32'h4,32'h8);
      tbl[6]  = v(0,1,0,0, 0,1,32'hDEAD_BEEF, 0,32'h8,0,NOP,32'h4,32'h8);
      tbl[7]  = v(0,1,0,0, 1,0,0,             0,32'h8,0,NOP,32'h4,32'h8);
      tbl[8]  = v(0,1,0,0, 1,0,0,             0,32'h8,0,NOP,32'h4,32'h8);
      tbl[9]  = v(0,0,0,0, 0,0,0,             0,32'h8,1,32'hDEAD_BEEF,32'h8,32'hC);
      tbl[10] = v(0,0,0,0, 1,0,0,             1,32'hC,0,NOP,32'h8,32'hC);
      tbl[11] = v(0,0,0,0, 0,1,32'hA000_000C, 0,32'hC,1,32'hA000_000C,32'hC,32'h10);

      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < 12; i++) run(tbl[i]);

      // redirect to 0x100 while waiting on 0x10
      run(v(0,0,0,0, 1,0,0,              1,32'h10,0,NOP,32'hC,32'h10));
      run(v(0,0,1,32'h100, 0,0,0,        0,32'h10,0,NOP,32'hC,32'h10));
      run(v(0,0,0,0, 0,1,32'hBAD0_0010,  0,32'h100,0,NOP,32'hC,32'h10));
      run(v(0,0,0,0, 1,0,0,              1,32'h100,0,NOP,32'hC,32'h10));
      run(v(0,0,0,0, 0,1,32'hA000_0100,  0,32'h100,1,32'hA000_0100,32'h100,32'h104));

      // redirect to 0x203 while stalled in HOLD
      run(v(0,1,0,0, 1,0,0,              1,32'h104,1,32'hA000_0100,32'h100,32'h104));
      run(v(0,1,0,0, 0,1,32'hCAFE_0104,  0,32'h104,1,32'hA000_0100,32'h100,32'h104));
      run(v(0,1,1,32'h203, 0,0,0,        0,32'h104,0,NOP,32'h100,32'h104));
      run(v(0,0,0,0, 1,0,0,              1,32'h200,0,NOP,32'h100,32'h104));
      run(v(0,0,0,0, 0,1,32'hA000_0200,  0,32'h200,1,32'hA000_0200,32'h200,32'h204));

      // reset while in WAIT, then a stray rvalid
      run(v(0,0,0,0, 1,0,0,              1,32'h204,0,NOP,32'h200,32'h204));
      run(v(1,0,0,0, 0,0,0,              0,32'h204,0,NOP,32'h0,32'h4));
      run(v(0,0,0,0, 0,1,32'hBAD0_0204,  1,32'h0,0,NOP,32'h0,32'h4));
      run(v(0,0,0,0, 1,0,0,              1,32'h0,0,NOP,32'h0,32'h4));
      run(v(0,0,0,0, 0,1,32'hA000_0000,  0,32'h0,1,32'hA000_0000,32'h0,32'h4));

      // redirect to top of memory, PC+4 wraps
      run(v(0,0,1,32'hFFFF_FFFC, 0,0,0,  1,32'h4,0,NOP,32'h0,32'h4));
      run(v(0,0,0,0, 1,0,0,              1,32'hFFFF_FFFC,0,NOP,32'h0,32'h4));
      run(v(0,0,0,0, 0,1,32'hA000_FFFC,  0,32'hFFFF_FFFC,1,32'hA000_FFFC,32'hFFFF_FFFC,32'h0));
      run(v(0,0,0,0, 1,0,0,              1,32'h0,0,NOP,32'hFFFF_FFFC,32'h0));
      run(v(0,0,0,0, 0,1,32'hA000_0000,  0,32'h0,1,32'hA000_0000,32'h0,32'h4));

      // redirect in REQ on the accept cycle: old response must be killed
      run(v(0,0,1,32'h40, 1,0,0,         1,32'h4,0,NOP,32'h0,32'h4));
      run(v(0,0,0,0, 0,1,32'hBAD0_0004,  0,32'h40,0,NOP,32'h0,32'h4));
      run(v(0,0,0,0, 1,0,0,              1,32'h40,0,NOP,32'h0,32'h4));
      run(v(0,0,0,0, 0,1,32'hA000_0040,  0,32'h40,1,32'hA000_0040,32'h40,32'h44));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
